serial_rx: RTL
==============

# serial_rx

Serial receive front end of the microcontroller. It deserialises the asynchronous 8N1 line `RD` into bytes and buffers them in a FIFO. The FIFO read side is the `RX_Data`/`RX_Full`/`RX_Empty`/`Data_Read` interface consumed by the receive DMA, which pops up to three bytes per bus grant.

## Interface
Parameters:
- `BIT_CYCLES`, default 174: `Clk` cycles per serial bit (20 MHz / 115200). Must be ≥ 4 and even.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of 2, ≥ 2.

Ports:
- `Clk`  in  1: single system clock, rising edge.
- `Rst`  in  1: synchronous, active-high reset.
- `RD`  in  1: asynchronous serial line. Idle is 1.
- `RX_Data`  out  8: registered byte popped by the last `Data_Read`.
- `RX_Full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `RX_Empty`  out  1: FIFO holds 0 entries.
- `Data_Read`  in  1: pop request, one cycle per byte.
- `Frame_Err`  out  1: one-cycle pulse when a byte is discarded for a bad stop bit.
- `Overrun`  out  1: one-cycle pulse when a good byte is discarded because the FIFO is full.

## Operation
- `RD` passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised `rd_s`.
- Receiver FSM states:
  - `IDLE`: on `rd_s` == 0, load `bit_cnt` = `BIT_CYCLES`/2 − 1 and go to `START`.
  - `START`: at `bit_cnt` == 0, sample `rd_s`. If 1, treat it as a glitch and return to `IDLE`. If 0, load `BIT_CYCLES` − 1, clear the bit index, and go to `DATA`.
  - `DATA`: at each `bit_cnt` == 0, shift `rd_s` into `shreg` bit 7 (right shift, LSB received first) and reload. After bit index 7, go to `STOP`.
  - `STOP`: at `bit_cnt` == 0, sample `rd_s`. If 1, push `shreg`, or pulse `Overrun` if the FIFO is full. If 0, pulse `Frame_Err` and push nothing. Go to `IDLE` in both cases.
- `bit_cnt` is a down-counter of width $clog2(`BIT_CYCLES`).
- FIFO:
  - `FIFO_DEPTH` × 8 storage.
  - Read and write pointers of width $clog2(`FIFO_DEPTH`), wrapping naturally.
  - `count` is one bit wider than the pointers.
- Pop:
  - `Data_Read` with `count` > 0: `RX_Data` ← mem[rd_ptr] and rd_ptr increments.
  - `Data_Read` while empty: ignored. `RX_Data` and pointers are unchanged.
- Simultaneous push and pop in one cycle:
  - Both occur and `count` is unchanged.
  - A push on a full FIFO in the same cycle as a pop is accepted (no overrun).
  - A push and pop on an empty FIFO: the pop is ignored and the push is stored.
- Reset values:
  - `RX_Data` = 0, `RX_Empty` = 1, `RX_Full` = 0, `Frame_Err` = 0, `Overrun` = 0.
  - FSM in `IDLE`; pointers and `count` = 0.
- Reset asserted mid-frame or with data buffered:
  - Everything is discarded and the FSM returns to `IDLE`.
  - A frame already in progress on `RD` after reset release is resynchronised from the next falling edge. Because its bits may produce false starts, a garbage byte or `Frame_Err` is acceptable.

## Timing
- Start edge to start-bit sample: `BIT_CYCLES`/2 cycles, after the 2-cycle synchroniser delay.
- Each data bit is sampled `BIT_CYCLES` after the previous sample, at mid-bit.
- Push occurs in the stop-bit sample cycle. `RX_Empty` falls, and `RX_Full` rises if the FIFO becomes full, on the next edge.
- `Data_Read` in cycle N: `RX_Data`, `RX_Empty` and `RX_Full` are all updated at edge N+1 and are valid together in cycle N+1. The DMA reads the data and tests `RX_Empty` in that same cycle.
- Back-to-back pops on consecutive cycles are supported at full rate.
- `Frame_Err` and `Overrun` are high for exactly one cycle, coincident with the cycle after the stop sample.

## Structure
- `global_pkg` gains:
  - `SERIAL_BIT_CYCLES` and `SERIAL_FIFO_DEPTH` constants, used as the top-level parameter values.
  - `rx_state_t` enum {`IDLE`, `START`, `DATA`, `STOP`}.
- One sub-module, `serial_rx_fifo`:
  - Parameterised synchronous FIFO.
  - Push/pop inputs; registered `Dout`, `Full`, `Empty` outputs; `Overrun` generation.
  - Instantiated once.
- The synchroniser, counters and FSM stay in `serial_rx`.

## Test plan
All scenarios use `BIT_CYCLES` = 8 and `FIFO_DEPTH` = 4.
- Reset, then idle `RD` = 1 for 200 cycles -> `RX_Empty` = 1, `RX_Data` = 0, no error pulses.
- Frame 0xA5 (8N1, LSB first), then one `Data_Read` -> `RX_Empty` falls after the stop sample; the cycle after `Data_Read`, `RX_Data` = 0xA5 and `RX_Empty` = 1.
- Frames 0x01, 0x02, 0x03, then 3 consecutive `Data_Read` cycles (DMA pattern) -> `RX_Data` = 0x01, 0x02, 0x03 on successive cycles; `RX_Empty` = 0, 0, 1.
- 5 frames 0x10..0x14 with no reads -> `RX_Full` = 1 after the 4th; one `Overrun` pulse on the 5th; subsequent pops return 0x10..0x13.
- Frame 0x3C with stop bit 0 -> one `Frame_Err` pulse, FIFO stays empty. A 3-cycle low glitch on idle `RD` -> no byte, no error.
- `Rst` asserted mid data-bit 4 with 2 bytes buffered -> `RX_Empty` = 1, FSM `IDLE`. The next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/global_pkg.sv
// Shared constants and types for the serial receive front end.
package global_pkg;

  localparam int SERIAL_BIT_CYCLES = 174;
  localparam int SERIAL_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_rx_fifo.sv
// Byte FIFO with registered read port, registered flags and an overrun pulse
// for pushes that find no free slot.
module serial_rx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Push,
  input  logic [7:0] Din,
  input  logic       Pop,
  output logic [7:0] Dout,
  output logic       Full,
  output logic       Empty,
  output logic       Overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a push onto a full FIFO
  // alongside a pop still lands.
  assign do_pop  = Pop && (count != '0);
  assign do_push = Push && ((count != FULL_CNT) || do_pop);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[wr_ptr] <= Din;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      Dout    <= 8'h00;
      Full    <= 1'b0;
      Empty   <= 1'b1;
      Overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        Dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_next;
      Full    <= (count_next == FULL_CNT);
      Empty   <= (count_next == '0);
      Overrun <= Push && !do_push;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver: line synchroniser, mid-bit sampling FSM and a byte
// FIFO feeding the receive DMA.
module serial_rx
  import global_pkg::*;
#(
  parameter int BIT_CYCLES = SERIAL_BIT_CYCLES,
  parameter int FIFO_DEPTH = SERIAL_FIFO_DEPTH
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RD,
  output logic [7:0] RX_Data,
  output logic       RX_Full,
  output logic       RX_Empty,
  input  logic       Data_Read,
  output logic       Frame_Err,
  output logic       Overrun
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);

  logic          rd_meta;
  logic          rd_s;
  rx_state_t     state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_meta <= 1'b1;
      rd_s    <= 1'b1;
    end else begin
      rd_meta <= RD;
      rd_s    <= rd_meta;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= 8'h00;
      Frame_Err <= 1'b0;
    end else begin
      Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rd_s) begin
            bit_cnt <= HALF_LOAD;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            // A start bit that has gone high again by mid-bit is a glitch.
            if (rd_s) begin
              state <= IDLE;
            end else begin
              bit_cnt <= FULL_LOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            shreg   <= {rd_s, shreg[7:1]};
            bit_cnt <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            Frame_Err <= !rd_s;
            state     <= IDLE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push = (state == STOP) && (bit_cnt == '0) && rd_s;

  serial_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clk    (Clk),
    .Rst    (Rst),
    .Push   (push),
    .Din    (shreg),
    .Pop    (Data_Read),
    .Dout   (RX_Data),
    .Full   (RX_Full),
    .Empty  (RX_Empty),
    .Overrun(Overrun)
  );

endmodule
